// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin share of one sprite ROM read port.
// Returns the palette index to the granted requester after ROM_LAT+1 cycles.
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 4,
   parameter int ROM_LAT = 1
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy
);

   localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

   logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d;
   logic [ROM_LAT-1:0]           vld_q, vld_d;
   logic [ROM_LAT-1:0][ID_W-1:0] id_q, id_d;
   logic                         rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;

   logic                         hit;
   logic [ID_W-1:0]              win;
   logic [ID_W:0]                idx_w;
   logic [ID_W-1:0]              idx;

   // Rotating priority search from rr_ptr; masked to no grant during reset
   always_comb begin
      gnt   = '0;
      hit   = 1'b0;
      win   = '0;
      idx_w = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (idx_w >= NR) idx_w = idx_w - NR;
         idx = idx_w[ID_W-1:0];
         if (reset_n && !hit && req[idx]) begin
            hit      = 1'b1;
            win      = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

   // Next-state: issue, pointer advance, latency pipe and response capture
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rom_addr_d = rom_addr_q;
      vld_d      = '0;
      id_d       = '0;
      if (hit) begin
         rom_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
         if ({1'b0, win} == NR - 1'b1) rr_ptr_d = '0;
         else                          rr_ptr_d = win + 1'b1;
      end
      vld_d[0] = hit;
      id_d[0]  = win;
      for (int s = 1; s < ROM_LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         id_d[s]  = id_q[s-1];
      end
      rsp_valid_d = vld_q[ROM_LAT-1];
      rsp_id_d    = id_q[ROM_LAT-1];
      rsp_data_d  = vld_q[ROM_LAT-1] ? rom_q : rsp_data_q;
   end

   // State registers; reset drops everything in flight
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q    <= '0;
         rom_addr_q  <= '0;
         vld_q       <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rom_addr_q  <= rom_addr_d;
         vld_q       <= vld_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = |vld_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed + random stimulus on two instances
// (ROM_LAT=1 and ROM_LAT=3) against a transaction-level reference model.
module tb_sprite_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [39:0] req_addr;

   logic [3:0]  gnt1, gnt3;
   logic [9:0]  rom_addr1, rom_addr3;
   logic [3:0]  rom_q1, rom_q3;
   logic        rsp_valid1, rsp_valid3;
   logic [1:0]  rsp_id1, rsp_id3;
   logic [3:0]  rsp_data1, rsp_data3;
   logic        busy1, busy3;
   logic [9:0]  dly1, dly2;

   always #5 clk = ~clk;

   sprite_rom_arbiter #(.NUM_REQ(4), .ID_W(2), .ADDR_W(10),
                        .DATA_W(4), .ROM_LAT(1)) dut1 (
      .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .gnt(gnt1), .rom_addr(rom_addr1), .rom_q(rom_q1),
      .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
      .busy(busy1));

   sprite_rom_arbiter #(.NUM_REQ(4), .ID_W(2), .ADDR_W(10),
                        .DATA_W(4), .ROM_LAT(3)) dut3 (
      .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .gnt(gnt3), .rom_addr(rom_addr3), .rom_q(rom_q3),
      .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
      .busy(busy3));

   // ROM models: word = low 4 address bits; latency 1 is the address
   // register itself, latency 3 adds two more register stages.
   assign rom_q1 = rom_addr1[3:0];
   always @(posedge clk) begin
      dly1 <= rom_addr3;
      dly2 <= dly1;
   end
   assign rom_q3 = dly2[3:0];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model state
   int         m_rr;
   logic [9:0] m_addr;
   logic [3:0] m_last [2];
   int         m_gq [$];
   logic [5:0] m_rsp [int];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rr      = 0;
      m_addr    = '0;
      m_last[0] = '0;
      m_last[1] = '0;
      m_gq.delete();
      m_rsp.delete();
   endtask

   function automatic bit busy_exp(input int lat);
      foreach (m_gq[i])
         if (m_gq[i] >= cyc - lat && m_gq[i] <= cyc - 1) return 1'b1;
      return 1'b0;
   endfunction

   // one clock cycle: drive, check all outputs, advance the model
   task automatic step(input logic rn, input logic [3:0] r,
                       input logic [39:0] a);
      logic [3:0] eg;
      int         w;
      int         lat;
      int         key;
      logic [3:0] vg;
      logic [9:0] vaddr;
      logic       vv, vb;
      logic [1:0] vid;
      logic [3:0] vd;
      @(negedge clk);
      reset_n  = rn;
      req      = r;
      req_addr = a;
      #1;
      if (!rn) model_reset();
      eg = '0;
      w  = 0;
      if (rn) begin
         for (int k = 0; k < 4; k++) begin
            if (eg == 4'b0 && r[(m_rr + k) % 4]) begin
               w  = (m_rr + k) % 4;
               eg = 4'(1 << w);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         lat   = (d == 0) ? 1 : 3;
         vg    = (d == 0) ? gnt1 : gnt3;
         vaddr = (d == 0) ? rom_addr1 : rom_addr3;
         vv    = (d == 0) ? rsp_valid1 : rsp_valid3;
         vid   = (d == 0) ? rsp_id1 : rsp_id3;
         vd    = (d == 0) ? rsp_data1 : rsp_data3;
         vb    = (d == 0) ? busy1 : busy3;
         chk($sformatf("gnt_l%0d", lat), 32'(vg), 32'(eg));
         chk($sformatf("rom_addr_l%0d", lat), 32'(vaddr), 32'(m_addr));
         chk($sformatf("busy_l%0d", lat), 32'(vb), 32'(busy_exp(lat)));
         key = cyc * 2 + d;
         if (m_rsp.exists(key)) begin
            chk($sformatf("rsp_valid_l%0d", lat), 32'(vv), 32'd1);
            chk($sformatf("rsp_id_l%0d", lat), 32'(vid), 32'(m_rsp[key][5:4]));
            m_last[d] = m_rsp[key][3:0];
         end else begin
            chk($sformatf("rsp_valid_l%0d", lat), 32'(vv), 32'd0);
         end
         chk($sformatf("rsp_data_l%0d", lat), 32'(vd), 32'(m_last[d]));
      end
      if (rn && eg != 4'b0) begin
         m_addr = a[w*10 +: 10];
         m_rr   = (w + 1) % 4;
         m_gq.push_back(cyc);
         m_rsp[(cyc + 2) * 2 + 0] = {2'(w), m_addr[3:0]};
         m_rsp[(cyc + 4) * 2 + 1] = {2'(w), m_addr[3:0]};
      end
      while (m_gq.size() > 0 && m_gq[0] < cyc - 4) void'(m_gq.pop_front());
      cyc++;
   endtask

   function automatic logic [39:0] rnd_addr();
      return {$urandom, $urandom};
   endfunction

   initial begin
      reset_n  = 1'b0;
      req      = '0;
      req_addr = '0;
      model_reset();
      // reset held with all requesting
      repeat (3) step(1'b0, 4'b1111, rnd_addr());
      // release: requester 0 first
      step(1'b1, 4'b1111, rnd_addr());
      repeat (5) step(1'b1, 4'b0000, rnd_addr());
      // single request, address 37 on slot 2
      step(1'b1, 4'b0100, 40'(10'd37) << 20);
      repeat (6) step(1'b1, 4'b0000, rnd_addr());
      // round robin, all requesting
      repeat (8) step(1'b1, 4'b1111, rnd_addr());
      // wrap then 1001 alternates 0/3
      step(1'b1, 4'b1111, rnd_addr());
      repeat (4) step(1'b1, 4'b1001, rnd_addr());
      // req1 held while req0 wins, then granted
      step(1'b1, 4'b0011, rnd_addr());
      step(1'b1, 4'b0010, rnd_addr());
      // move pointer, then req2 pulsed while req3 wins
      step(1'b1, 4'b1000, rnd_addr());
      step(1'b1, 4'b0100, rnd_addr());
      step(1'b1, 4'b1100, rnd_addr());
      repeat (6) step(1'b1, 4'b0000, rnd_addr());
      // reset mid-flight
      step(1'b1, 4'b0010, rnd_addr());
      step(1'b1, 4'b0000, rnd_addr());
      step(1'b0, 4'b0000, rnd_addr());
      repeat (6) step(1'b1, 4'b0000, rnd_addr());
      // reset in the same cycle as a request
      step(1'b0, 4'b0100, rnd_addr());
      repeat (6) step(1'b1, 4'b0000, rnd_addr());
      // single requester back to back
      repeat (6) step(1'b1, 4'b0010, rnd_addr());
      // random traffic with rare resets
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 49) != 0), 4'($urandom), rnd_addr());
      repeat (6) step(1'b1, 4'b0000, rnd_addr());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Time-shares one sprite ROM read port among NUM_REQ sprite-layer requesters (P1 head, P2 head, body segments, food) in the per-pixel draw pipeline.
- Uses a round-robin valid/grant handshake and drives the shared ROM address.
- Returns the ROM palette index to the winning requester, tagged with its requester ID, at a fixed latency.
- Sits between the sprite layer engines and the shared sprite ROM / palette path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- ADDR_W, 10, ROM address width.
- DATA_W, 4, ROM word (palette index) width.
- ROM_LAT, 1, cycles from rom_addr registered to rom_q valid (1..3).

Ports:
- vga_clk  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request (bit i = requester i).
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant; combinational from req and rr_ptr.
- rom_addr  out  ADDR_W  registered address to the shared ROM.
- rom_q  in  DATA_W  ROM read data.
- rsp_valid  out  1  response valid, one cycle per granted request.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  DATA_W  captured rom_q.
- busy  out  1  high while any issued read is still in flight.

Behaviour:
- Reset (async, reset_n=0):
  - rr_ptr=0; rom_addr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - All pipeline valid bits cleared; busy=0.
  - gnt=0 while reset_n=0.
- Handshake:
  - A requester holds req[i] and a stable address until it sees gnt[i]=1.
  - The transfer completes at the posedge where req[i]&gnt[i]=1.
  - The requester may drop or change its address on the following cycle.
  - A request deasserted before grant is simply withdrawn; no error.
- Arbitration, combinational every cycle:
  - Search req starting at index rr_ptr, ascending with wrap at NUM_REQ-1 -> 0.
  - The first set bit wins; gnt is one-hot or all-zero.
  - At most one grant per cycle; throughput is one read per cycle.
- Issue, at posedge with winner w:
  - rom_addr <= req_addr slice w.
  - Stage-0 pipeline valid<=1, id<=w.
  - rr_ptr <= (w+1) mod NUM_REQ.
- No winner: rom_addr holds its value; stage-0 valid<=0; rr_ptr unchanged.
- Pipeline:
  - Shift register of {valid,id}, depth ROM_LAT, advances every cycle.
  - At the posedge following the tail stage: rsp_valid <= tail.valid, rsp_id <= tail.id, rsp_data <= rom_q (captured only when tail.valid=1, else held).
- Latency:
  - Grant cycle is cycle 0.
  - rom_addr is updated after edge 1.
  - rsp_valid is high for exactly cycle ROM_LAT+1 (ROM_LAT=1: response in cycle 2).
- Responses are in grant order; no reordering. Back-to-back grants give back-to-back rsp_valid.
- busy = OR of all pipeline valid bits.
- Fairness: with all requesters permanently requesting, each is granted once every NUM_REQ cycles, in order ptr, ptr+1, ...
- Boundaries:
  - Single requester: granted every cycle.
  - rr_ptr wrap: after NUM_REQ-1 is granted, rr_ptr=0.
  - Reset mid-flight: in-flight responses are discarded. No rsp_valid appears after reset release until a new grant plus latency.
  - Reset asserted in the same cycle as a grant: that grant does not issue.
  - A request arriving while the pipeline is busy is granted normally; there is no backpressure from the response side.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, rom_addr=0. Release -> cycle 0 gnt=4'b0001.
- Single request, ROM_LAT=1: req=4'b0100 with addr 10'd37 for one cycle; ROM model returns addr[3:0] -> rom_addr=37 in cycle 1; rsp_valid=1, rsp_id=2, rsp_data=4'h5 in cycle 2 only; busy=1 in cycle 1.
- Round-robin: req=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3. Responses carry rsp_id 0,1,2,3,0,1,2,3 on consecutive cycles.
- Fairness after wrap: grant 3, then req=4'b1001 -> next grant is 0, then 3, then 0.
- Withdraw and hold: req1 high while req0 is granted -> req1 granted next cycle. req2 pulsed for a cycle where req3 wins -> no response with id 2.
- Reset mid-flight with ROM_LAT=3: grant id 1, then assert reset_n=0 two cycles later for one cycle -> no rsp_valid for id 1; busy=0 immediately during reset.
